// File: rtl/perceptron_trainer_pkg.sv
// perceptron_trainer_pkg: shared defaults and FSM encoding for the perceptron weight store
package perceptron_trainer_pkg;
  localparam int N_INPUTS_DEF = 7;
  localparam int W_WIDTH_DEF = 8;
  localparam logic [7:0] LR_DEF = 8'h10;
  localparam logic [7:0] WEIGHT_INIT_DEF = 8'h80;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    BIAS   = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: training-sample handshake into the perceptron trainer
interface perceptron_trainer_if #(parameter int N_INPUTS = 7);
  logic valid;
  logic ready;
  logic [N_INPUTS-1:0] sample;
  logic label;
  logic pred;
  modport master (output valid, sample, label, pred, input ready);
  modport slave (input valid, sample, label, pred, output ready);
endinterface

// File: rtl/perceptron_trainer_sat_addsub.sv
// perceptron_trainer_sat_addsub: unsigned add/subtract clamped to [0, all-ones]
module perceptron_trainer_sat_addsub #(
  parameter int W_WIDTH = 8
) (
  input  logic [W_WIDTH-1:0] a,
  input  logic [W_WIDTH-1:0] b,
  input  logic               sub,
  output logic [W_WIDTH-1:0] y
);
  logic [W_WIDTH:0] r;
  always_comb begin
    r = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    y = r[W_WIDTH] ? (sub ? '0 : '1) : r[W_WIDTH-1:0];
  end
endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: serial perceptron learning-rule update of the weight/bias store
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int                 N_INPUTS    = N_INPUTS_DEF,
  parameter int                 W_WIDTH     = W_WIDTH_DEF,
  parameter logic [W_WIDTH-1:0] LR          = W_WIDTH'(LR_DEF),
  parameter logic [W_WIDTH-1:0] WEIGHT_INIT = W_WIDTH'(WEIGHT_INIT_DEF),
  localparam int                IW          = $clog2(N_INPUTS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  perceptron_trainer_if.slave s,
  output logic                busy,
  output logic                done,
  output logic                changed,
  output logic [15:0]         err_count,
  input  logic [IW-1:0]       rd_idx,
  output logic [W_WIDTH-1:0]  rd_data
);
  state_t state, state_nx;
  logic [W_WIDTH-1:0] w [N_INPUTS+1];
  logic [N_INPUTS-1:0] sample_q;
  logic dir_q, err_q, accept, err_in;
  logic [IW-1:0] idx, sel;
  logic [W_WIDTH-1:0] upd;
  assign s.ready = state == IDLE;
  assign accept = s.valid && s.ready;
  assign err_in = s.label ^ s.pred;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign changed = done && err_q;
  // bias lives in the last slot so one adder serves weights and bias
  assign sel = state == BIAS ? IW'(N_INPUTS) : idx;
  perceptron_trainer_sat_addsub #(.W_WIDTH(W_WIDTH)) u_sat (
    .a(w[sel]),
    .b(LR),
    .sub(!dir_q),
    .y(upd)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? (err_in ? UPDATE : DONE) : IDLE) :
               state == UPDATE ? (idx == IW'(N_INPUTS - 1) ? BIAS : UPDATE) :
               state == BIAS ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i <= N_INPUTS; i++) w[i] <= WEIGHT_INIT;
      sample_q <= '0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
      idx <= '0;
      err_count <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      idx <= state == UPDATE ? idx + IW'(1) : '0;
      if (accept) begin
        sample_q <= s.sample;
        dir_q <= s.label;
        err_q <= err_in;
        if (err_in && err_count != '1) err_count <= err_count + 16'd1;
      end
      if ((state == UPDATE && sample_q[idx]) || state == BIAS) w[sel] <= upd;
      rd_data <= rd_idx <= IW'(N_INPUTS) ? w[rd_idx] : '0;
    end
  end
endmodule
